// File: rtl/audio_pdm_out.sv
// Audio output stage: PSG/tape source select, click-free gain crossfade and a
// 2nd-order delta-sigma modulator. Define AUDIO_DITHER_EN to add LFSR dither.
module audio_pdm_out #(
  parameter int               WIDTH      = 14,
  parameter logic [WIDTH-1:0] TAPE_LEVEL = 14'h2000,
  parameter int               RAMP_DIV   = 256
) (
  input  logic             clk_i,
  input  logic             res_n_i,
  input  logic [WIDTH-1:0] psg_in,
  input  logic             tape_in,
  input  logic             sel_in,
  output logic             dac_o,
  output logic             busy_o,
  output logic             sel_active_o
);
  localparam int IW = WIDTH + 4;
  localparam int SW = IW + 2;
  localparam int RW = $clog2(RAMP_DIV);
  localparam logic [RW-1:0]        RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [WIDTH-1:0]     FULL      = '1;
  localparam logic signed [SW-1:0] SAT_HI    = SW'((1 << (IW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO    = SW'(-(1 << (IW - 1)));

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  function automatic logic signed [SW-1:0] ext_i(input logic signed [IW-1:0] v);
    return {{(SW - IW){v[IW-1]}}, v};
  endfunction

  function automatic logic signed [IW-1:0] sat_i(input logic signed [SW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > SAT_HI) r = SAT_HI[IW-1:0];
    else if (v < SAT_LO) r = SAT_LO[IW-1:0];
    else r = v[IW-1:0];
    return r;
  endfunction

  state_t               state_r, state_n;
  logic [6:0]           gain_r, gain_n;
  logic [RW-1:0]        ramp_r, ramp_n;
  logic                 sel_r, sel_active_r, sel_active_n, busy_r, dac_r, tick_s;
  logic [WIDTH-1:0]     src_s, x_s, x_r, xm_s;
  logic signed [IW-1:0] i1_r, i2_r, i1n_s, i2n_s;
  logic signed [SW-1:0] fb_s, xe_s;

  assign dac_o        = dac_r;
  assign busy_o       = busy_r;
  assign sel_active_o = sel_active_r;
  assign tick_s       = (ramp_r == RAMP_LAST);

  // source mux and gain scaling; gain=64 passes src unchanged
  always_comb begin
    if (sel_active_r) begin
      if (tape_in) src_s = TAPE_LEVEL;
      else src_s = '0;
    end else begin
      src_s = psg_in;
    end
    x_s = WIDTH'(({7'd0, src_s} * {{WIDTH{1'b0}}, gain_r}) >> 3'd6);
  end

`ifdef AUDIO_DITHER_EN
  logic [15:0]    lfsr_r;
  logic [WIDTH:0] xd_s;

  // dither LFSR, taps 16/14/13/11
  always_ff @(posedge clk_i) begin
    if (!res_n_i) lfsr_r <= 16'hACE1;
    else lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  end

  // add dither, clamp at full scale
  always_comb begin
    xd_s = {1'b0, x_r} + {{(WIDTH - 1){1'b0}}, lfsr_r[1:0]};
    if (xd_s[WIDTH]) xm_s = FULL;
    else xm_s = xd_s[WIDTH-1:0];
  end
`else
  assign xm_s = x_r;
`endif

  // fade sequencer: a fade may reverse mid-ramp from the current gain
  always_comb begin
    state_n      = state_r;
    gain_n       = gain_r;
    ramp_n       = '0;
    sel_active_n = sel_active_r;
    case (state_r)
      PLAY: begin
        if (sel_r != sel_active_r) state_n = FADE_OUT;
        else state_n = PLAY;
      end
      FADE_OUT: begin
        if (sel_r == sel_active_r) state_n = FADE_IN;
        else if (gain_r == 7'd0) state_n = SWITCH;
        else if (tick_s) begin
          gain_n = gain_r - 7'd1;
          if (gain_r == 7'd1) state_n = SWITCH;
          else state_n = FADE_OUT;
        end else ramp_n = ramp_r + RW'(1);
      end
      SWITCH: begin
        sel_active_n = sel_r;
        state_n      = FADE_IN;
      end
      FADE_IN: begin
        if (sel_r != sel_active_r) state_n = FADE_OUT;
        else if (gain_r == 7'd64) state_n = PLAY;
        else if (tick_s) begin
          gain_n = gain_r + 7'd1;
          if (gain_r == 7'd63) state_n = PLAY;
          else state_n = FADE_IN;
        end else ramp_n = ramp_r + RW'(1);
      end
      default: begin
        state_n = PLAY;
        gain_n  = 7'd64;
      end
    endcase
  end

  // control registers; reset adopts sel_in directly with no fade
  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      state_r      <= PLAY;
      gain_r       <= 7'd64;
      ramp_r       <= '0;
      sel_r        <= sel_in;
      sel_active_r <= sel_in;
      busy_r       <= 1'b0;
      x_r          <= '0;
    end else begin
      state_r      <= state_n;
      gain_r       <= gain_n;
      ramp_r       <= ramp_n;
      sel_r        <= sel_in;
      sel_active_r <= sel_active_n;
      busy_r       <= (state_n != PLAY);
      x_r          <= x_s;
    end
  end

  // 2nd-order modulator arithmetic with saturating integrators
  always_comb begin
    if (dac_r) fb_s = $signed({{(SW - WIDTH){1'b0}}, FULL});
    else fb_s = '0;
    xe_s  = $signed({{(SW - WIDTH){1'b0}}, xm_s});
    i1n_s = sat_i(ext_i(i1_r) + xe_s - fb_s);
    i2n_s = sat_i(ext_i(i2_r) + ext_i(i1n_s) - fb_s);
  end

  // modulator state and 1-bit quantizer
  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      i1_r  <= '0;
      i2_r  <= '0;
      dac_r <= 1'b0;
    end else begin
      i1_r  <= i1n_s;
      i2_r  <= i2n_s;
      dac_r <= !i2n_s[IW-1] && (i2n_s != '0);
    end
  end
endmodule

// File: tb/tb_audio_pdm_out.sv
// Scoreboard bench for audio_pdm_out: windows of expected output counts are queued
// by the stimulus and checked by an independent monitor.
module tb_audio_pdm_out;
  localparam int WIDTH = 14;
  localparam int R     = 4;
  localparam int FULL  = (1 << WIDTH) - 1;
  localparam int TAPE  = 8192;

  logic             clk = 1'b0;
  logic             res_n;
  logic [WIDTH-1:0] psg_in;
  logic             tape_in, sel_in;
  logic             dac, busy, sel_act;

  audio_pdm_out #(.WIDTH(WIDTH), .TAPE_LEVEL(14'h2000), .RAMP_DIV(R)) dut (
    .clk_i(clk), .res_n_i(res_n), .psg_in(psg_in), .tape_in(tape_in), .sel_in(sel_in),
    .dac_o(dac), .busy_o(busy), .sel_active_o(sel_act)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start; int len;
    bit cd; int dlo; int dhi;
    bit cb; int blo; int bhi;
    bit cs; int slo; int shi;
  } win_t;

  win_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_on = 1'b0;

  task automatic check(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic push_win(input string nm, input int start, input int len,
                          input bit cd, input int dlo, input int dhi,
                          input bit cb, input int blo, input int bhi,
                          input bit cs, input int slo, input int shi);
    win_t w;
    w.start = start; w.len = len;
    w.cd = cd; w.dlo = dlo; w.dhi = dhi;
    w.cb = cb; w.blo = blo; w.bhi = bhi;
    w.cs = cs; w.slo = slo; w.shi = shi;
    exp_q.push_back(w);
    name_q.push_back(nm);
  endtask

  // monitor: counts ones of each output over the window at the queue head
  initial begin
    win_t  w;
    string nm;
    int    nd, nb, ns;
    nd = 0; nb = 0; ns = 0;
    forever begin
      @(negedge clk);
      if (!mon_on && exp_q.size() != 0 && exp_q[0].start <= cyc) begin
        w  = exp_q.pop_front();
        nm = name_q.pop_front();
        mon_on = 1'b1;
        nd = 0; nb = 0; ns = 0;
      end
      if (mon_on) begin
        nd += int'(dac);
        nb += int'(busy);
        ns += int'(sel_act);
        if (cyc >= w.start + w.len - 1) begin
          if (w.cd) check({nm, ".dac_ones"}, nd, w.dlo, w.dhi);
          if (w.cb) check({nm, ".busy_cycles"}, nb, w.blo, w.bhi);
          if (w.cs) check({nm, ".sel_active_cycles"}, ns, w.slo, w.shi);
          mon_on = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "cycle budget exhausted");
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // density model: ones over N cycles = N * x / FULL
  task automatic density(input string nm, input int x, input int tol, input bit act);
    int start, e;
    start = cyc + 1 + 64;
    e = (4096 * x + FULL / 2) / FULL;
    push_win(nm, start, 4096, 1'b1, e - tol, e + tol, 1'b1, 0, 0,
             1'b1, act ? 4096 : 0, act ? 4096 : 0);
    step_to(start + 4096);
  endtask

  // full switch: 1 sync + 64R out + 1 SWITCH + 64R in
  task automatic full_switch(input string nm, input bit new_sel);
    int k, s_ones;
    k = cyc;
    sel_in = new_sel;
    s_ones = new_sel ? 600 - (2 + 64 * R) : 2 + 64 * R;
    push_win(nm, k + 1, 600, 1'b0, 0, 0, 1'b1, 128 * R + 1, 128 * R + 1, 1'b1, s_ones, s_ones);
    step_to(k + 601);
  endtask

  // aborted fade from active=1: n steps down, the same n steps back up
  task automatic abort_fade(input string nm, input int n);
    int k, w;
    k = cyc;
    w = n * R + R / 2;
    sel_in = 1'b0;
    push_win(nm, k + 1, 600, 1'b0, 0, 0, 1'b1, w + n * R, w + n * R, 1'b1, 600, 600);
    step_to(k + w);
    sel_in = 1'b1;
    step_to(k + 601);
  endtask

  initial begin
    int k;
    res_n = 1'b0; sel_in = 1'b1; tape_in = 1'b0; psg_in = '0;
    repeat (5) @(posedge clk);
    #1;
    res_n = 1'b1;
    push_win("reset_first", cyc, 1, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 1, 1);
    push_win("reset_idle", cyc + 1, 50, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 50, 50);
    step_to(cyc + 52);

    tape_in = 1'b1;
    density("tape_level", TAPE, 4, 1'b1);
    tape_in = 1'b0;
    full_switch("switch_to_psg", 1'b0);

    psg_in = 14'h0000;
    k = cyc;
    push_win("psg_zero", k + 1, 1000, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 0, 0);
    step_to(k + 1001);
    psg_in = 14'h3FFF;
    k = cyc;
    push_win("psg_full", k + 1 + 8, 1000, 1'b1, 1000, 1000, 1'b1, 0, 0, 1'b1, 0, 0);
    step_to(k + 1009);

    psg_in = 14'h2000;
    density("psg_half", 32'h2000, 4, 1'b0);
    psg_in = 14'h1000;
    density("psg_quarter", 32'h1000, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      int v;
      v = $urandom_range(32'h3800, 32'h0800);
      psg_in = WIDTH'(v);
      density($sformatf("psg_rand%0d_%0h", i, v), v, 6, 1'b0);
    end

    full_switch("switch_to_tape", 1'b1);
    abort_fade("abort_gain40", 24);
    abort_fade("abort_rand", $urandom_range(60, 1));

    psg_in = '0; tape_in = 1'b0;
    k = cyc;
    sel_in = 1'b0;
    push_win("fade_before_reset", k + 1, 399, 1'b0, 0, 0, 1'b1, 398, 398, 1'b1, 2 + 64 * R, 2 + 64 * R);
    step_to(k + 400);
    res_n = 1'b0;
    sel_in = 1'b1;
    @(posedge clk);
    #1;
    res_n = 1'b1;
    push_win("after_mid_reset", cyc, 300, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 300, 300);
    step_to(cyc + 301);
    tape_in = 1'b1;
    density("tape_after_reset", TAPE, 4, 1'b1);

    for (int i = 0; i < 20000 && (exp_q.size() != 0 || mon_on); i++) @(posedge clk);
    if (exp_q.size() != 0 || mon_on) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d windows still pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
